// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch / control-flow sequencer for the 16-bit processor
module fetch_sequencer #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [15:0] pc_value,
    output logic        pc_load,
    output logic        pc_inc,
    output logic [15:0] pc_in,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic [15:0] ir,
    input  logic        zero_flag,
    output logic        exec_start,
    input  logic        exec_done,
    output logic        halted,
    output logic        error,
    output logic [2:0]  state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_FETCH2 = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;
    localparam logic [2:0] S_ERROR  = 3'd6;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_JMP  = 4'h1;
    localparam logic [3:0] OP_JZ   = 4'h2;
    localparam logic [3:0] OP_JNZ  = 4'h3;
    localparam logic [3:0] OP_JMPL = 4'h4;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    logic [2:0]  state_q;
    logic [2:0]  state_d;
    logic [15:0] ir_q;
    logic [7:0]  wait_q;
    logic [3:0]  opcode;
    logic [15:0] jmp_target;
    logic [2:0]  boundary_state;
    logic        in_fetch;

    assign opcode         = ir_q[15:12];
    assign jmp_target     = {4'h0, ir_q[11:0]};
    assign boundary_state = run ? S_FETCH : S_IDLE;
    assign in_fetch       = (state_q == S_FETCH) || (state_q == S_FETCH2);

    // Every output is a pure decode of state and inputs, so reset alone zeroes them.
    always_comb begin
        state_d    = state_q;
        pc_load    = 1'b0;
        pc_inc     = 1'b0;
        pc_in      = 16'h0000;
        mem_req    = 1'b0;
        exec_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    pc_inc  = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LIMIT) begin
                    state_d = S_ERROR;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_NOP: begin
                        state_d = boundary_state;
                    end
                    OP_JMP: begin
                        pc_load = 1'b1;
                        pc_in   = jmp_target;
                        state_d = boundary_state;
                    end
                    OP_JZ: begin
                        if (zero_flag) begin
                            pc_load = 1'b1;
                            pc_in   = jmp_target;
                        end
                        state_d = boundary_state;
                    end
                    OP_JNZ: begin
                        if (!zero_flag) begin
                            pc_load = 1'b1;
                            pc_in   = jmp_target;
                        end
                        state_d = boundary_state;
                    end
                    OP_JMPL: begin
                        state_d = S_FETCH2;
                    end
                    OP_HALT: begin
                        state_d = S_HALT;
                    end
                    default: begin
                        exec_start = 1'b1;
                        state_d    = S_EXEC;
                    end
                endcase
            end
            S_EXEC: begin
                if (exec_done) begin
                    state_d = boundary_state;
                end
            end
            S_FETCH2: begin
                // PC already points past the JMPL word, so mem_addr is the operand address.
                mem_req = 1'b1;
                if (mem_ack) begin
                    pc_load = 1'b1;
                    pc_in   = mem_rdata;
                    state_d = boundary_state;
                end else if (wait_q == WAIT_LIMIT) begin
                    state_d = S_ERROR;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_ERROR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ir_q    <= 16'h0000;
            wait_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            if ((state_q == S_FETCH) && mem_ack) begin
                ir_q <= mem_rdata;
            end
            // Counter restarts on any entry to a fetch state and only runs while waiting.
            if (in_fetch && (state_d == state_q)) begin
                wait_q <= wait_q + 8'd1;
            end else begin
                wait_q <= 8'h00;
            end
        end
    end

    assign mem_addr = pc_value;
    assign ir       = ir_q;
    assign halted   = (state_q == S_HALT);
    assign error    = (state_q == S_ERROR);
    assign state    = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed and randomized checks of fetch_sequencer against an instruction-level model
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic [15:0] pc = 16'h0000;
    logic        pc_load;
    logic        pc_inc;
    logic [15:0] pc_in;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_ack = 1'b0;
    logic [15:0] ir;
    logic        zero_flag = 1'b0;
    logic        exec_start;
    logic        exec_done = 1'b0;
    logic        halted;
    logic        error;
    logic [2:0]  state;

    int nerr = 0;
    int nchk = 0;

    bit [15:0] mem [0:65535];
    int lat_fixed = 0;
    bit noack = 0;
    bit stray = 0;
    bit rand_on = 0;
    bit done_dir = 0;
    int wcnt = 0;
    int lat = 0;
    int ecnt = 0;
    logic ex_prev = 1'b0;

    logic [2:0]  tr_state [1:16];
    logic        tr_inc   [1:16];
    logic        tr_load  [1:16];
    logic [15:0] tr_pcin  [1:16];
    logic        tr_req   [1:16];
    logic [15:0] tr_addr  [1:16];
    logic [15:0] tr_pc    [1:16];
    logic        tr_exs   [1:16];
    logic        tr_err   [1:16];
    logic        tr_halt  [1:16];

    fetch_sequencer #(.MAX_WAIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .pc_value   (pc),
        .pc_load    (pc_load),
        .pc_inc     (pc_inc),
        .pc_in      (pc_in),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .ir         (ir),
        .zero_flag  (zero_flag),
        .exec_start (exec_start),
        .exec_done  (exec_done),
        .halted     (halted),
        .error      (error),
        .state      (state)
    );

    always #5 clk = ~clk;

    // Stand-in for the program counter block.
    always @(posedge clk or posedge rst) begin
        if (rst) pc <= 16'h0000;
        else if (pc_load) pc <= pc_in;
        else if (pc_inc) pc <= pc + 16'd1;
    end

    always @(negedge clk) ex_prev <= exec_start;

    function automatic int pick_lat();
        return (lat_fixed >= 0) ? lat_fixed : $urandom_range(0, 3);
    endfunction

    // Memory, execute-unit and environment responders.
    always begin
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        if (rst) begin
            wcnt = 0;
            lat  = pick_lat();
        end else if (mem_req) begin
            if (!noack && wcnt == lat) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr];
                wcnt      = 0;
                lat       = pick_lat();
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
            if (stray && $urandom_range(0, 5) == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = 16'($urandom);
            end
        end
        if (done_dir) begin
            if (ex_prev) ecnt = 1;
            else if (ecnt != 0) ecnt++;
            exec_done = (ecnt == 3);
        end else begin
            exec_done = rand_on && ($urandom_range(0, 2) == 0);
        end
        if (rand_on) begin
            zero_flag = 1'($urandom_range(0, 1));
            run       = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_inv();
        check("inv", {29'b0, pc_load & pc_inc, !pc_load && (pc_in != 16'h0), mem_addr != pc}, 32'h0);
    endtask

    task automatic apply_reset(input logic r);
        @(posedge clk);
        #3;
        rst = 1'b1;
        run = 1'b0;
        @(negedge clk);
        check("reset_outs", {pc_load, pc_inc, mem_req, exec_start, halted, error, state, 4'h0, pc_in},
              32'h0);
        check("reset_ir_addr", {ir, mem_addr}, 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        run = r;
    endtask

    task automatic capture(input int n);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            tr_state[i] = state;
            tr_inc[i]   = pc_inc;
            tr_load[i]  = pc_load;
            tr_pcin[i]  = pc_in;
            tr_req[i]   = mem_req;
            tr_addr[i]  = mem_addr;
            tr_pc[i]    = pc;
            tr_exs[i]   = exec_start;
            tr_err[i]   = error;
            tr_halt[i]  = halted;
            check_inv();
        end
    endtask

    logic [15:0] rec_addr [$];
    logic [15:0] rec_data [$];
    bit          rec_zf   [$];
    bit          rec_zv   [$];

    initial begin
        logic [15:0] jops  [4];
        logic        jzf   [4];
        logic [15:0] jaddr [4];
        logic        jload [4];
        int          exs_cnt;
        bit          pend;
        bit          ended;
        int          exs_obs;
        logic [15:0] exp_pc;
        bit          operand;
        int          exec_exp;
        bit          halt_exp;
        logic [15:0] w;

        // NOP, NOP with zero-wait memory
        lat_fixed = 0;
        mem[0] = 16'h0000;
        mem[1] = 16'h0000;
        apply_reset(1'b1);
        capture(5);
        check("nop_state_c1", 32'(tr_state[1]), 32'd0);
        check("nop_inc_c2", 32'(tr_inc[2]), 32'd1);
        check("nop_inc_c3", 32'(tr_inc[3]), 32'd0);
        check("nop_inc_c4", 32'(tr_inc[4]), 32'd1);
        check("nop_pc_c5", 32'(tr_pc[5]), 32'd2);

        // JMP 0xABC
        mem[0] = 16'h1ABC;
        mem[16'h0ABC] = 16'h0000;
        apply_reset(1'b1);
        capture(5);
        check("jmp_load_c3", 32'(tr_load[3]), 32'd1);
        check("jmp_pcin_c3", 32'(tr_pcin[3]), 32'h0ABC);
        check("jmp_load_c4", 32'(tr_load[4]), 32'd0);
        check("jmp_fetch_c4", {15'b0, tr_req[4], tr_addr[4]}, {15'b0, 1'b1, 16'h0ABC});

        // JZ / JNZ with both flag values
        jops  = '{16'h2010, 16'h2010, 16'h3010, 16'h3010};
        jzf   = '{1'b0, 1'b1, 1'b0, 1'b1};
        jaddr = '{16'h0001, 16'h0010, 16'h0010, 16'h0001};
        jload = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int t = 0; t < 4; t++) begin
            mem[0] = jops[t];
            zero_flag = jzf[t];
            apply_reset(1'b1);
            capture(4);
            check($sformatf("cond%0d_load", t), 32'(tr_load[3]), 32'(jload[t]));
            check($sformatf("cond%0d_addr", t), {15'b0, tr_req[4], tr_addr[4]}, {15'b0, 1'b1, jaddr[t]});
        end
        zero_flag = 1'b0;

        // JMPL with operand 0x1234
        mem[0] = 16'h4000;
        mem[1] = 16'h1234;
        mem[16'h1234] = 16'h0000;
        apply_reset(1'b1);
        capture(5);
        check("jmpl_addr_c2", 32'(tr_addr[2]), 32'h0);
        check("jmpl_fetch2_c4", {15'b0, tr_req[4], tr_addr[4]}, {15'b0, 1'b1, 16'h0001});
        check("jmpl_load_c4", {15'b0, tr_load[4], tr_pcin[4]}, {15'b0, 1'b1, 16'h1234});
        check("jmpl_inc_c4", 32'(tr_inc[4]), 32'd0);
        check("jmpl_next_c5", 32'(tr_addr[5]), 32'h1234);

        // EXEC-class with done in the third EXEC cycle
        mem[0] = 16'h5000;
        mem[1] = 16'h0000;
        done_dir = 1;
        apply_reset(1'b1);
        capture(8);
        exs_cnt = 0;
        for (int i = 1; i <= 8; i++) exs_cnt += int'(tr_exs[i]);
        check("exec_pulses", 32'(exs_cnt), 32'd1);
        check("exec_start_c3", 32'(tr_exs[3]), 32'd1);
        check("exec_states", {tr_state[4], tr_state[5], tr_state[6], tr_state[7]}, {3'd3, 3'd3, 3'd3, 3'd1});
        done_dir = 0;

        // HALT
        mem[0] = 16'hF000;
        apply_reset(1'b1);
        capture(5);
        check("halt_c4", {tr_state[4], tr_halt[4]}, {3'd5, 1'b1});
        check("halt_hold_c5", {tr_state[5], tr_req[5]}, {3'd5, 1'b0});

        // Reset asserted in the middle of a fetch
        mem[0] = 16'h0000;
        noack = 1;
        apply_reset(1'b1);
        capture(3);
        check("midfetch_req", 32'(tr_req[3]), 32'd1);

        // Timeout with no ack: ERROR after the 5th FETCH cycle
        apply_reset(1'b1);
        capture(8);
        check("to_fetch_c6", {tr_state[6], tr_req[6]}, {3'd1, 1'b1});
        check("to_error_c7", {tr_state[7], tr_err[7], tr_req[7]}, {3'd6, 1'b1, 1'b0});
        check("to_sticky_c8", {tr_state[8], tr_err[8]}, {3'd6, 1'b1});
        noack = 0;
        apply_reset(1'b0);
        capture(2);
        check("post_err_idle", {tr_state[2], tr_err[2], tr_req[2]}, 32'h0);

        // Ack in the timeout cycle wins
        lat_fixed = 4;
        apply_reset(1'b1);
        capture(8);
        check("ackwin_c7", {tr_state[7], tr_err[7]}, {3'd2, 1'b0});
        check("ackwin_c8", 32'(tr_addr[8]), 32'h0001);

        // Randomized program against the instruction-level model
        for (int i = 0; i < 65536; i++) begin
            w = 16'($urandom);
            if (w[15:12] == 4'hF && $urandom_range(0, 31) != 0) w[15:12] = 4'h0;
            mem[i] = w;
        end
        lat_fixed = -1;
        apply_reset(1'b1);
        rand_on = 1;
        stray   = 1;
        pend    = 0;
        ended   = 0;
        exs_obs = 0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(negedge clk);
            check_inv();
            if (pend) begin
                rec_zf[rec_zf.size() - 1] = zero_flag;
                rec_zv[rec_zv.size() - 1] = 1'b1;
                pend = 0;
            end
            if (exec_start) exs_obs++;
            if (mem_req && mem_ack) begin
                rec_addr.push_back(mem_addr);
                rec_data.push_back(mem_rdata);
                rec_zf.push_back(1'b0);
                rec_zv.push_back(1'b0);
                pend = 1;
            end
            if (halted || (rec_addr.size() >= 400 && !pend)) begin
                ended = 1;
                break;
            end
        end
        rand_on = 0;
        stray   = 0;
        check("rand_end", 32'(ended), 32'd1);

        exp_pc   = 16'h0000;
        operand  = 0;
        exec_exp = 0;
        halt_exp = 0;
        for (int k = 0; k < rec_addr.size(); k++) begin
            if (halt_exp) break;
            if (!operand && !rec_zv[k]) break;
            check($sformatf("fetch_addr[%0d]", k), 32'(rec_addr[k]), 32'(exp_pc));
            if (operand) begin
                exp_pc  = rec_data[k];
                operand = 0;
            end else begin
                exp_pc = rec_addr[k] + 16'd1;
                case (rec_data[k][15:12])
                    4'h0: ;
                    4'h1: exp_pc = {4'h0, rec_data[k][11:0]};
                    4'h2: if (rec_zf[k]) exp_pc = {4'h0, rec_data[k][11:0]};
                    4'h3: if (!rec_zf[k]) exp_pc = {4'h0, rec_data[k][11:0]};
                    4'h4: operand = 1;
                    4'hF: halt_exp = 1;
                    default: exec_exp++;
                endcase
            end
        end
        check("rand_exec_count", 32'(exs_obs), 32'(exec_exp));
        check("rand_halted", 32'(halted), 32'(halt_exp));
        check("rand_no_error", 32'(error), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch and control sequencer for the 16-bit processor. It owns the `program_counter` control inputs (`load`, `inc`, `in`), fetches instruction words over a req/ack memory port, and decodes control-flow opcodes itself. All other opcodes are handed to the execute datapath through a start/done handshake. It sits between the program counter, instruction memory and the execute unit.

## Interface
- `MAX_WAIT`, default 255: memory-ack timeout in cycles; range 1..255.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `run`  in  1  enable. Sampled only at instruction boundaries.
- `pc_value`  in  16  current program counter output.
- `pc_load`  out  1  drives PC `load`.
- `pc_inc`  out  1  drives PC `inc`.
- `pc_in`  out  16  drives PC `in`.
- `mem_req`  out  1  read request; held until ack.
- `mem_addr`  out  16  read address; always equals `pc_value`.
- `mem_rdata`  in  16  read data, valid when `mem_ack` is high.
- `mem_ack`  in  1  single-cycle read completion.
- `ir`  out  16  instruction register.
- `zero_flag`  in  1  condition flag from the execute unit.
- `exec_start`  out  1  one-cycle start pulse to the execute unit.
- `exec_done`  in  1  execute completion.
- `halted`  out  1  high in HALT.
- `error`  out  1  high in ERROR; sticky.
- `state`  out  3  current state encoding.

## Operation
- Opcode is `ir[15:12]`:
  - 0x0 NOP.
  - 0x1 JMP: target is `{4'h0, ir[11:0]}`.
  - 0x2 JZ: jump if `zero_flag`.
  - 0x3 JNZ: jump if `!zero_flag`.
  - 0x4 JMPL: 16-bit target in the next word.
  - 0xF HALT.
  - All other opcodes are EXEC-class.
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, FETCH2=4, HALT=5, ERROR=6.
- IDLE: when `run`=1, go to FETCH.
- FETCH:
  - `mem_req`=1.
  - On `mem_ack`: `ir`<=`mem_rdata`, `pc_inc`=1 in the same cycle, then go to DECODE.
- DECODE (exactly one cycle):
  - NOP: go to boundary.
  - JMP: `pc_load`=1, `pc_in`=target, then go to boundary.
  - JZ / JNZ: same as JMP if the condition holds, otherwise no PC action; then go to boundary.
  - JMPL: go to FETCH2.
  - HALT: go to HALT.
  - EXEC-class: `exec_start`=1, then go to EXEC.
- EXEC: wait for `exec_done`, then go to boundary.
- FETCH2:
  - `mem_req`=1; `mem_addr` is the already-incremented PC.
  - On `mem_ack`: `pc_load`=1, `pc_in`=`mem_rdata`, then go to boundary.
- Boundary: next state is FETCH if `run`=1, otherwise IDLE.
- HALT and ERROR exit only through `rst`.
- Timeout:
  - An 8-bit wait counter clears on entry to FETCH/FETCH2 and increments each cycle without `mem_ack`.
  - When the count reaches `MAX_WAIT` with no ack, go to ERROR and drop `mem_req`.
  - An ack arriving in the same cycle as the timeout wins.
- Output rules:
  - `pc_load` and `pc_inc` are never high together.
  - Both are zero outside the listed conditions.
  - `pc_in`=0 whenever `pc_load`=0.

## Timing
- Reset (asynchronous) forces state IDLE, `ir`=0, wait counter 0.
- All outputs are decoded from state and inputs, so during reset every output is 0, including `mem_req`, `exec_start`, `halted`, `error` and `state`=0. This also holds when reset asserts mid-fetch.
- `pc_inc`, `pc_load` and `exec_start` are Mealy outputs: high for exactly one cycle, and the PC updates on that same edge.
- Minimum instruction time with zero-wait memory (ack in the first FETCH cycle):
  - NOP/jump: 2 cycles.
  - JMPL: 3 cycles.
  - EXEC-class: 2 cycles plus the cycles until `exec_done`.
- `exec_done` is ignored outside EXEC.
- `mem_ack` is ignored outside FETCH/FETCH2.
- `zero_flag` is sampled in the DECODE cycle.
- `run` is sampled only in IDLE and at boundary transitions. Deasserting `run` never aborts an instruction in progress.

## Test plan
- Reset then `run`=1 with zero-wait memory holding NOP, NOP at addresses 0 and 1 -> `pc_inc` pulses on cycles 2 and 4, and PC reads 2 after 4 cycles.
- Instruction 0x1ABC at PC 0 -> `pc_load` for one cycle with `pc_in`=0x0ABC, followed by a FETCH with `mem_addr`=0x0ABC.
- 0x2010 with `zero_flag`=0 -> no load, next fetch at 1; rerun with `zero_flag`=1 -> next fetch at 0x0010. Run JNZ with the inverse flag values and check the inverse results.
- 0x4000 followed by word 0x1234 -> two fetches at addresses 0 and 1, then `pc_load` with 0x1234.
- Opcode 0x5 with `exec_done` delayed 3 cycles -> a single `exec_start` pulse, 3 cycles in EXEC, then FETCH.
- `MAX_WAIT`=4 with no ack -> ERROR on the 5th FETCH cycle, `error`=1, `mem_req`=0; a later `rst` returns to IDLE with all outputs 0.
